// File: rtl/onehot_req_arbiter.sv
// onehot_req_arbiter: captures request pulses on eight lines as pending
// bits and hands them out one at a time as a registered one-hot grant.
module onehot_req_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       ack,
   input  logic       clr_ovf,
   output logic [7:0] grant,
   output logic       valid,
   output logic [7:0] pending,
   output logic       ovf
);

   logic [2:0] ptr;
   logic [7:0] retire;
   logic [7:0] pending_next;
   logic       dup;
   logic       ovf_next;
   logic       free;
   logic [7:0] cand;
   logic       found;
   logic [2:0] pick;
   logic [7:0] grant_next;
   logic       valid_next;
   logic [2:0] ptr_next;

   // Pending bookkeeping: retire acked grant, merge new pulses, flag drops.
   always_comb begin
      retire       = (valid && ack) ? grant : 8'h00;
      pending_next = (pending & ~retire) | req;
      dup          = |(req & pending & ~retire);
      ovf_next     = ovf;
      if (clr_ovf) ovf_next = 1'b0;
      if (dup)     ovf_next = 1'b1;
   end

   // Round-robin search: first candidate at or above ptr, wrapping 7 to 0.
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] idx;
         idx = ptr + 3'(i);
         if (!found && cand[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Output slot control: load a new grant, go idle, or hold under backpressure.
   always_comb begin
      free       = !valid || ack;
      cand       = pending & ~grant;
      grant_next = grant;
      valid_next = valid;
      ptr_next   = ptr;
      if (free) begin
         if (found) begin
            grant_next = 8'h01 << pick;
            valid_next = 1'b1;
            ptr_next   = pick + 3'd1;
         end else begin
            grant_next = 8'h00;
            valid_next = 1'b0;
         end
      end
   end

   // State registers; everything clears at once on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 8'h00;
         grant   <= 8'h00;
         valid   <= 1'b0;
         ovf     <= 1'b0;
         ptr     <= 3'd0;
      end else begin
         pending <= pending_next;
         grant   <= grant_next;
         valid   <= valid_next;
         ovf     <= ovf_next;
         ptr     <= ptr_next;
      end
   end

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// tb_onehot_req_arbiter: directed tests of the round-robin one-hot
// arbiter, including the downstream 8-to-3 encoder view of grant.
module tb_onehot_req_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       ack;
   logic       clr_ovf;
   logic [7:0] grant;
   logic       valid;
   logic [7:0] pending;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   onehot_req_arbiter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .ack     (ack),
      .clr_ovf (clr_ovf),
      .grant   (grant),
      .valid   (valid),
      .pending (pending),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] enc8to3(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) r = 3'(i);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 8'h00; ack = 1'b0; clr_ovf = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req = 8'h00; ack = 1'b0; clr_ovf = 1'b0; rst_n = 1'b0;
      step(); step();
      checks++;
      if ({grant, valid, pending, ovf} !== 18'h0) begin
         errors++;
         $display("FAIL reset_init: grant=%h valid=%b pending=%h ovf=%b, want 00 0 00 0",
                  grant, valid, pending, ovf);
      end
      rst_n = 1'b1;
      req = 8'hFF; step(); req = 8'h00;
      req = 8'h01; step(); req = 8'h00;
      checks++;
      if (!(pending === 8'hFF && valid === 1'b1 && grant === 8'h01 && ovf === 1'b1)) begin
         errors++;
         $display("FAIL reset_setup: pending=%h valid=%b grant=%h ovf=%b, want ff 1 01 1",
                  pending, valid, grant, ovf);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, valid, pending, ovf} !== 18'h0) begin
         errors++;
         $display("FAIL reset_async: grant=%h valid=%b pending=%h ovf=%b, want 00 0 00 0",
                  grant, valid, pending, ovf);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      req = 8'h08; step(); req = 8'h00;
      checks++;
      if (pending !== 8'h08 || valid !== 1'b0) begin
         errors++;
         $display("FAIL single_e0: pending=%h valid=%b, want 08 0", pending, valid);
      end
      step();
      checks++;
      if (grant !== 8'h08 || valid !== 1'b1) begin
         errors++;
         $display("FAIL single_e1: grant=%h valid=%b, want 08 1", grant, valid);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (grant !== 8'h08 || valid !== 1'b1 || pending !== 8'h08) begin
            errors++;
            $display("FAIL single_hold%0d: grant=%h valid=%b pending=%h, want 08 1 08",
                     i, grant, valid, pending);
         end
      end
      ack = 1'b1; step(); ack = 1'b0;
      checks++;
      if (valid !== 1'b0 || pending !== 8'h00 || grant !== 8'h00) begin
         errors++;
         $display("FAIL single_ack: valid=%b pending=%h grant=%h, want 0 00 00",
                  valid, pending, grant);
      end
      ack = 1'b1; step(); ack = 1'b0;
      checks++;
      if ({grant, valid, pending, ovf} !== 18'h0) begin
         errors++;
         $display("FAIL idle_ack: grant=%h valid=%b pending=%h ovf=%b, want all zero",
                  grant, valid, pending, ovf);
      end
   endtask

   task automatic test_fairness();
      logic [7:0] exp;
      do_reset();
      ack = 1'b1;
      req = 8'h81; step(); req = 8'h00;
      step();
      checks++;
      if (grant !== 8'h01 || valid !== 1'b1) begin
         errors++;
         $display("FAIL fair81_first: grant=%h valid=%b, want 01 1", grant, valid);
      end
      step();
      checks++;
      if (grant !== 8'h80 || valid !== 1'b1 || pending !== 8'h80) begin
         errors++;
         $display("FAIL fair81_second: grant=%h valid=%b pending=%h, want 80 1 80",
                  grant, valid, pending);
      end
      step();
      checks++;
      if (valid !== 1'b0 || grant !== 8'h00) begin
         errors++;
         $display("FAIL fair81_idle: grant=%h valid=%b, want 00 0", grant, valid);
      end
      do_reset();
      ack = 1'b1;
      req = 8'hFF; step(); req = 8'h00;
      for (int k = 0; k < 8; k++) begin
         step();
         exp = 8'h01 << k;
         checks++;
         if (grant !== exp || valid !== 1'b1) begin
            errors++;
            $display("FAIL rotate%0d: grant=%h valid=%b, want %h 1", k, grant, valid, exp);
         end
      end
      req = 8'hFF; step(); req = 8'h00;
      checks++;
      if (pending !== 8'hFF || valid !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL rotate_rereq: pending=%h valid=%b ovf=%b, want ff 0 0",
                  pending, valid, ovf);
      end
      step();
      checks++;
      if (grant !== 8'h01 || valid !== 1'b1) begin
         errors++;
         $display("FAIL rotate_wrap: grant=%h valid=%b, want 01 1", grant, valid);
      end
      ack = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      req = 8'h04; step(); req = 8'h00;
      step();
      req = 8'h04; step(); req = 8'h00;
      checks++;
      if (ovf !== 1'b1 || pending !== 8'h04 || grant !== 8'h04) begin
         errors++;
         $display("FAIL ovf_dup: ovf=%b pending=%h grant=%h, want 1 04 04",
                  ovf, pending, grant);
      end
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      checks++;
      if (ovf !== 1'b0 || grant !== 8'h04 || valid !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clear1: ovf=%b grant=%h valid=%b, want 0 04 1",
                  ovf, grant, valid);
      end
      req = 8'h04; ack = 1'b1; step(); req = 8'h00; ack = 1'b0;
      checks++;
      if (ovf !== 1'b0 || pending !== 8'h04 || valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_ackreq: ovf=%b pending=%h valid=%b, want 0 04 0",
                  ovf, pending, valid);
      end
      step();
      checks++;
      if (grant !== 8'h04 || valid !== 1'b1) begin
         errors++;
         $display("FAIL ovf_regrant: grant=%h valid=%b, want 04 1", grant, valid);
      end
      req = 8'h04; clr_ovf = 1'b1; step(); req = 8'h00; clr_ovf = 1'b0;
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_setwins: ovf=%b, want 1", ovf);
      end
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear2: ovf=%b, want 0", ovf);
      end
   endtask

   task automatic test_encoder();
      do_reset();
      req = 8'h20; step(); req = 8'h00;
      step();
      checks++;
      if (valid !== 1'b1 || enc8to3(grant) !== 3'b101 || !$onehot(grant)) begin
         errors++;
         $display("FAIL enc_first: valid=%b grant=%h enc=%b, want 1 20 101",
                  valid, grant, enc8to3(grant));
      end
      req = 8'h40; step(); req = 8'h00;
      checks++;
      if (valid !== 1'b1 || grant !== 8'h20 || pending !== 8'h60) begin
         errors++;
         $display("FAIL enc_hold: valid=%b grant=%h pending=%h, want 1 20 60",
                  valid, grant, pending);
      end
      ack = 1'b1; step(); ack = 1'b0;
      checks++;
      if (valid !== 1'b1 || enc8to3(grant) !== 3'b110 || !$onehot(grant)
          || (grant & ~pending) !== 8'h00) begin
         errors++;
         $display("FAIL enc_b2b: valid=%b grant=%h pending=%h enc=%b, want 1 40 40 110",
                  valid, grant, pending, enc8to3(grant));
      end
      ack = 1'b1; step(); ack = 1'b0;
      checks++;
      if (valid !== 1'b0 || grant !== 8'h00 || pending !== 8'h00) begin
         errors++;
         $display("FAIL enc_done: valid=%b grant=%h pending=%h, want 0 00 00",
                  valid, grant, pending);
      end
   endtask

   initial begin
      rst_n = 1'b0; req = 8'h00; ack = 1'b0; clr_ovf = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_overflow();
      test_encoder();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/onehot_req_arbiter.md
# onehot_req_arbiter

Upstream stage of the 8-to-3 encoder. It captures single-cycle request pulses on eight lines, holds them as pending, and presents exactly one pending request at a time as a registered one-hot vector. Selection is round-robin. The one-hot output drives the encoder input directly, so the encoder never sees zero-hot or multi-hot codes while `valid` is high. Hand-off to the consumer uses a valid/ack handshake.

## Interface
Parameters:
- none (width fixed at 8 requesters, 3-bit pointer)

Ports:
- `clk`  input  1  system clock, all state updates on rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `req`  input  8  request pulses; bit k high for a cycle raises request k
- `ack`  input  1  consumer accepts current `grant`; meaningful only while `valid`=1
- `clr_ovf`  input  1  synchronous clear of `ovf`
- `grant`  output  8  registered one-hot selection; feeds the encoder input
- `valid`  output  1  `grant` holds a live request
- `pending`  output  8  registered pending-request vector, including the granted bit until it is acked
- `ovf`  output  1  sticky flag: a request was dropped

## Operation
- Reset (`rst_n`=0, asynchronous): `pending`=8'h00, `grant`=8'h00, `valid`=0, `ovf`=0, internal pointer `ptr`=3'd0.
- Retire: `retire` = `grant` when `valid`&&`ack`, otherwise 8'h00.
- Pending update: `pending_next` = (`pending` & ~`retire`) | `req`.
- Drop and overflow:
  - Overflow condition: `req`[k]=1 while `pending`[k]=1 and `retire`[k]=0.
  - The duplicate request is merged (dropped), and `ovf` sets.
  - `ovf` clears on `clr_ovf`=1; set wins if both happen in the same cycle.
- Output slot is free when `valid`=0, or when `valid`&&`ack`.
- Candidates: `cand` = `pending` & ~`grant`, where `grant` is the current register value. Same-cycle `req` bits are not candidates.
- Load: if the slot is free and `cand`!=0:
  - Choose the first set bit k searching from index `ptr` upward, wrapping 7→0.
  - `grant` ← one-hot(k), `valid` ← 1, `ptr` ← (k+1) mod 8 (3-bit natural wrap).
- Idle: if the slot is free and `cand`==0, `grant` ← 8'h00 and `valid` ← 0.
- Backpressure: if `valid`=1 and `ack`=0, `grant`, `valid` and `ptr` hold unchanged.
- `ack` while `valid`=0 is ignored and has no effect on any state.
- Invariants:
  - `grant` is zero-hot if and only if `valid`=0.
  - `grant` is a subset of `pending` at all times.

## Timing
- Request latency: `req` high at edge E0 sets `pending` after E0. If the slot is free, `grant`/`valid` update after E1 (2-edge latency).
- Back-to-back: with `ack` at edge En and another candidate present, the next `grant` appears after En. `valid` stays high, with no bubble.
- Ack-to-retire: the pending bit clears at the ack edge.
  - A re-request of the same bit on the ack cycle is accepted with no `ovf`.
  - It becomes eligible again at the following edge.
- Simultaneous events in one cycle (`req`, `ack`, `clr_ovf`): each update follows the rules above, all evaluated on pre-edge register values.
- Reset mid-operation: all state clears immediately. In-flight and pending requests are lost, and `ovf` is not set.
- `rst_n` deassertion is synchronized externally; no internal synchronizer.

## Test plan
- Reset: assert `rst_n`=0 mid-transfer with `pending`=8'hFF → outputs immediately `grant`=8'h00, `valid`=0, `pending`=8'h00, `ovf`=0.
- Single request: `req`=8'h08 for 1 cycle → after 2 edges `grant`=8'h08, `valid`=1.
  - Hold `ack`=0 for 5 cycles → `grant` stable.
  - Pulse `ack` → `valid`=0 and `pending`=8'h00 after that edge.
- Simultaneous and fairness: `req`=8'h81 for one cycle with `ack` tied high → `grant` sequence 8'h01 then 8'h80 on consecutive cycles, then `valid`=0.
  - With `req`=8'hFF pulsed repeatedly and `ack`=1 → grants rotate 01,02,04,…,80,01 with no bit repeated before all 8 are served.
- Overflow: `req`=8'h04, then `req`=8'h04 again before ack → `ovf`=1 and `pending`=8'h04.
  - Ack-cycle re-request of 8'h04 → no `ovf`, bit 2 granted again.
  - `clr_ovf` with a new duplicate in the same cycle → `ovf` stays 1.
  - `clr_ovf` alone → `ovf`=0.
- Encoder chain: feed `grant` into the 8-to-3 encoder and pulse `req`=8'h20 → encoder output 3'b101 while `valid`=1. Check for no glitch across a back-to-back switch to `req` bit 6 (3'b110).
